// File: rtl/sequencer_control.sv
// sequencer_control: Am2910-style microprogram sequencer controller.
// Decodes the 4-bit instruction and the condition input. It drives the
// address-mux select and the pipeline/map/vector enables. It also owns the
// uPC register, the loop register/counter R and the LIFO subroutine stack.
// Optional feature macro: SEQ_STACK_GUARD_EN
//   defined   -> a push at full is dropped and stack_err latches high until reset
//   undefined -> a push at full overwrites the top entry; stack_err is tied low
module sequencer_control #(
    parameter int AW          = 12,
    parameter int STACK_DEPTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    instr,
    input  logic          cc_en,
    input  logic          cc,
    input  logic          rld,
    input  logic          ci,
    input  logic [AW-1:0] d_in,
    input  logic [AW-1:0] y_in,
    output logic [1:0]    mux_sel,
    output logic          y_zero,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] r_out,
    output logic [AW-1:0] f_out,
    output logic          full,
    output logic          pl_en,
    output logic          map_en,
    output logic          vect_en,
    output logic          stack_err
);

    // SP counts occupied entries, so it needs to reach STACK_DEPTH itself
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam logic [SPW-1:0] SP_MAX   = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0] TOP_SLOT = SPW'(STACK_DEPTH - 1);
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_JSRP = 4'd5,
        OP_CJV  = 4'd6,
        OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,
        OP_RPCT = 4'd9,
        OP_CRTN = 4'd10,
        OP_CJPP = 4'd11,
        OP_LDCT = 4'd12,
        OP_LOOP = 4'd13,
        OP_CONT = 4'd14,
        OP_TWB  = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        SEL_PC = 2'b00,
        SEL_D  = 2'b01,
        SEL_R  = 2'b10,
        SEL_F  = 2'b11
    } sel_t;

    op_t             op;
    sel_t            sel;
    logic            pass;
    logic            rz;
    logic            push;
    logic            pop;
    logic            sp_clear;
    logic            r_ld_op;
    logic            r_dec;

    logic [AW-1:0]   upc;
    logic [AW-1:0]   r_reg;
    logic [SPW-1:0]  sp;
    logic [SPW-1:0]  top_idx;
    logic [AW-1:0]   stack_mem [STACK_DEPTH];

    assign op      = op_t'(instr);
    assign pass    = ~cc_en | cc;
    assign rz      = (r_reg == '0);
    assign top_idx = sp - SP_ONE;

    assign mux_sel = sel;
    assign pc_out  = upc;
    assign r_out   = r_reg;
    assign full    = (sp == SP_MAX);
    assign f_out   = (sp == '0) ? '0 : stack_mem[top_idx];

    // Instruction decode: the mux select, the enables and the stack/R actions, all combinational
    always_comb begin
        sel      = SEL_PC;
        y_zero   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        sp_clear = 1'b0;
        r_ld_op  = 1'b0;
        r_dec    = 1'b0;
        pl_en    = 1'b1;
        map_en   = 1'b0;
        vect_en  = 1'b0;
        case (op)
            OP_JZ: begin
                y_zero   = 1'b1;
                sel      = SEL_D;
                sp_clear = 1'b1;
            end
            OP_CJS: begin
                if (pass) begin
                    sel  = SEL_D;
                    push = 1'b1;
                end
            end
            OP_JMAP: begin
                sel    = SEL_D;
                map_en = 1'b1;
                pl_en  = 1'b0;
            end
            OP_CJP: begin
                if (pass) sel = SEL_D;
            end
            OP_PUSH: begin
                push = 1'b1;
                if (pass) r_ld_op = 1'b1;
            end
            OP_JSRP: begin
                push = 1'b1;
                sel  = pass ? SEL_D : SEL_R;
            end
            OP_CJV: begin
                vect_en = 1'b1;
                pl_en   = 1'b0;
                if (pass) sel = SEL_D;
            end
            OP_JRP: begin
                sel = pass ? SEL_D : SEL_R;
            end
            OP_RFCT: begin
                if (!rz) begin
                    sel   = SEL_F;
                    r_dec = 1'b1;
                end else begin
                    pop = 1'b1;
                end
            end
            OP_RPCT: begin
                if (!rz) begin
                    sel   = SEL_D;
                    r_dec = 1'b1;
                end
            end
            OP_CRTN: begin
                if (pass) begin
                    sel = SEL_F;
                    pop = 1'b1;
                end
            end
            OP_CJPP: begin
                if (pass) begin
                    sel = SEL_D;
                    pop = 1'b1;
                end
            end
            OP_LDCT: begin
                r_ld_op = 1'b1;
            end
            OP_LOOP: begin
                if (pass) pop = 1'b1;
                else      sel = SEL_F;
            end
            OP_CONT: begin
                sel = SEL_PC;
            end
            OP_TWB: begin
                if (pass) begin
                    pop = 1'b1;
                end else if (!rz) begin
                    sel   = SEL_F;
                    r_dec = 1'b1;
                end else begin
                    sel = SEL_D;
                    pop = 1'b1;
                end
            end
            default: begin
                sel = SEL_PC;
            end
        endcase
    end

    // uPC follows the mux output every cycle, plus the carry-in; it wraps at AW bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc <= '0;
        end else begin
            upc <= y_in + AW'(ci);
        end
    end

    // Loop register: an external load beats an instruction load, which beats a decrement; it never underflows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg <= '0;
        end else if (rld || r_ld_op) begin
            r_reg <= d_in;
        end else if (r_dec && !rz) begin
            r_reg <= r_reg - AW'(1);
        end
    end

    // Subroutine stack: JZ clears it, a push saves the current uPC, and a pop on an empty stack is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (sp_clear) begin
            sp <= '0;
        end else if (push) begin
            if (sp != SP_MAX) begin
                stack_mem[sp] <= upc;
                sp            <= sp + SP_ONE;
            end else begin
`ifdef SEQ_STACK_GUARD_EN
                sp <= sp;
`else
                stack_mem[TOP_SLOT] <= upc;
`endif
            end
        end else if (pop && sp != '0) begin
            sp <= sp - SP_ONE;
        end
    end

`ifdef SEQ_STACK_GUARD_EN
    // Sticky overflow flag: set by a push at full and cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stack_err <= 1'b0;
        end else if (push && !sp_clear && sp == SP_MAX) begin
            stack_err <= 1'b1;
        end
    end
`else
    assign stack_err = 1'b0;
`endif

endmodule
